// File: rtl/pps_pkg.sv
// Shared fetch/decode types and constants for the pps pipeline front end.
package pps_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] PC_RST_VEC = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_pkt_t;

endpackage

// File: rtl/pps_fifo_ram.sv
// DEPTH x 64-bit instruction/PC storage: one synchronous write port and an
// asynchronous read port addressed by the queue head.
module pps_fifo_ram
  import pps_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  if_pkt_t       wdata,
  input  logic [AW-1:0] raddr,
  output if_pkt_t       rdata
);

  if_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pps_fetch_queue.sv
// Instruction buffer plus IF/ID register between fetch and decode.
// Optional macro PPS_FETCH_QUEUE_STATS_EN adds stall_cnt/flush_cnt outputs.
module pps_fetch_queue
  import pps_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = pps_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  input  logic        id_stall,
  output logic        fetch_hold,
  output logic        id_vld,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [3:0]  occupancy
`ifdef PPS_FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [3:0]    count, count_nxt;
  logic          pop, push, bypass, overflow;
  if_pkt_t       head_pkt, in_pkt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_pkt = '{inst: in_inst, pc: in_pc};

  always_comb begin
    pop       = 1'b0;
    bypass    = 1'b0;
    push      = 1'b0;
    overflow  = 1'b0;
    count_nxt = count;
    if (!id_stall && !flush) begin
      pop    = (count != 4'd0);
      bypass = (count == 4'd0) && in_vld;
    end
    // A full queue only accepts a new entry when the head leaves this cycle.
    if (in_vld && !flush && !bypass) begin
      if (count < 4'(DEPTH) || pop) push = 1'b1;
      else                          overflow = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_nxt = count + 4'd1;
      2'b01:   count_nxt = count - 4'd1;
      default: count_nxt = count;
    endcase
  end

  pps_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_pkt),
    .raddr (rd_ptr),
    .rdata (head_pkt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      id_vld  <= 1'b0;
      id_inst <= NOP_INST;
      id_pc   <= 32'h0;
      count   <= 4'd0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      // Under stall the ID register is frozen, even on flush: it is the delay slot.
      if (!id_stall) begin
        if (flush) begin
          id_vld  <= 1'b0;
          id_inst <= NOP_INST;
        end else if (pop) begin
          id_vld  <= 1'b1;
          id_inst <= head_pkt.inst;
          id_pc   <= head_pkt.pc;
        end else if (bypass) begin
          id_vld  <= 1'b1;
          id_inst <= in_inst;
          id_pc   <= in_pc;
        end else begin
          id_vld  <= 1'b0;
          id_inst <= NOP_INST;
        end
      end
      if (flush) begin
        count  <= 4'd0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push) wr_ptr <= ptr_inc(wr_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!overflow);
  end

  // Hold one slot back for the instruction already in flight from SRAM.
  assign fetch_hold = (count >= 4'(DEPTH - 1));
  assign occupancy  = count;

`ifdef PPS_FETCH_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0;
      flush_cnt <= 16'h0;
    end else begin
      if (id_stall && id_vld && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)              flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pps_fetch_queue.sv
// Directed self-checking bench for pps_fetch_queue (DEPTH=2).
module tb_pps_fetch_queue;
  import pps_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_vld, flush, id_stall;
  logic [31:0] in_inst, in_pc;
  logic        fetch_hold, id_vld;
  logic [31:0] id_inst, id_pc;
  logic [3:0]  occupancy;
`ifdef PPS_FETCH_QUEUE_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pps_fetch_queue #(.DEPTH(2), .NOP_INST(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .flush      (flush),
    .id_stall   (id_stall),
    .fetch_hold (fetch_hold),
    .id_vld     (id_vld),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .occupancy  (occupancy)
`ifdef PPS_FETCH_QUEUE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    in_vld   = v;
    in_pc    = pc;
    in_inst  = pc ^ 32'hA5A5_0000;
    id_stall = st;
    flush    = fl;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic [3:0] occ, input logic hold);
    chk({tag, ".vld"},  {31'b0, id_vld}, {31'b0, v});
    chk({tag, ".pc"},   id_pc, pc);
    chk({tag, ".inst"}, id_inst, inst);
    chk({tag, ".occ"},  {28'b0, occupancy}, {28'b0, occ});
    chk({tag, ".hold"}, {31'b0, fetch_hold}, {31'b0, hold});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk_id("reset", 1'b0, 32'h0, NOP_INST, 4'd0, 1'b0);

    // bypass stream
    drive(1'b1, 32'h0, 1'b0, 1'b0); tick();
    chk_id("byp0", 1'b1, 32'h0, 32'hA5A5_0000, 4'd0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0); tick();
    chk_id("byp4", 1'b1, 32'h4, 32'hA5A5_0004, 4'd0, 1'b0);
    drive(1'b1, 32'h8, 1'b0, 1'b0); tick();
    chk_id("byp8", 1'b1, 32'h8, 32'hA5A5_0008, 4'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk_id("idle", 1'b0, 32'h8, NOP_INST, 4'd0, 1'b0);

    // stall while two instructions arrive
    drive(1'b1, 32'h10, 1'b1, 1'b0); tick();
    chk_id("stl1", 1'b0, 32'h8, NOP_INST, 4'd1, 1'b1);
    drive(1'b1, 32'h14, 1'b1, 1'b0); tick();
    chk_id("stl2", 1'b0, 32'h8, NOP_INST, 4'd2, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk_id("stl3", 1'b0, 32'h8, NOP_INST, 4'd2, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk_id("rel10", 1'b1, 32'h10, 32'hA5A5_0010, 4'd1, 1'b1);
    tick();
    chk_id("rel14", 1'b1, 32'h14, 32'hA5A5_0014, 4'd0, 1'b0);
    tick();
    chk_id("relidle", 1'b0, 32'h14, NOP_INST, 4'd0, 1'b0);

    // flush with a full queue; in-flight 0x20 is dropped
    drive(1'b1, 32'h18, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h1C, 1'b1, 1'b0); tick();
    chk_id("fill", 1'b0, 32'h14, NOP_INST, 4'd2, 1'b1);
    drive(1'b1, 32'h20, 1'b0, 1'b1); tick();
    chk_id("flush", 1'b0, 32'h14, NOP_INST, 4'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk_id("postfl", 1'b0, 32'h14, NOP_INST, 4'd0, 1'b0);

    // flush under stall keeps the delay slot in ID
    drive(1'b1, 32'h30, 1'b0, 1'b0); tick();
    chk_id("ds30", 1'b1, 32'h30, 32'hA5A5_0030, 4'd0, 1'b0);
    drive(1'b1, 32'h34, 1'b1, 1'b0); tick();
    chk_id("ds34q", 1'b1, 32'h30, 32'hA5A5_0030, 4'd1, 1'b1);
    drive(1'b1, 32'h38, 1'b1, 1'b1); tick();
    chk_id("dsfl", 1'b1, 32'h30, 32'hA5A5_0030, 4'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk_id("dsrel", 1'b0, 32'h30, NOP_INST, 4'd0, 1'b0);
`ifdef PPS_FETCH_QUEUE_STATS_EN
    chk("stall_cnt", {16'b0, stall_cnt}, 32'd2);
    chk("flush_cnt", {16'b0, flush_cnt}, 32'd2);
`endif

    // push and pop in the same cycle
    drive(1'b1, 32'h50, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h54, 1'b0, 1'b0); tick();
    chk_id("pp50", 1'b1, 32'h50, 32'hA5A5_0050, 4'd1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk_id("pp54", 1'b1, 32'h54, 32'hA5A5_0054, 4'd0, 1'b0);

    // reset with a full queue
    drive(1'b1, 32'h40, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h44, 1'b1, 1'b0); tick();
    chk_id("prerst", 1'b1, 32'h54, 32'hA5A5_0054, 4'd2, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk_id("midrst", 1'b0, 32'h0, NOP_INST, 4'd0, 1'b0);
`ifdef PPS_FETCH_QUEUE_STATS_EN
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'b0, flush_cnt}, 32'd0);

    // stall counter saturation
    drive(1'b1, 32'h60, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 70000; i++) tick();
    chk("stall_sat", {16'b0, stall_cnt}, 32'h0000_FFFF);
    chk("stall_sat_vld", {31'b0, id_vld}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pps_fetch_queue.md
Name: pps_fetch_queue

Overview:
- Instruction buffer and IF/ID pipeline register directly downstream of the fetch stage.
- Captures instruction/PC pairs returned by the instruction SRAM one cycle after fetch issues an address.
- Buffers them while decode stalls, presents one instruction per cycle to decode, and drops buffered wrong-path instructions on a branch stomp.
- Drives fetch's PC-hold input so that no returning instruction is ever lost.

Parameters:
- DEPTH, 2, queue entries; legal range 2..8.
- NOP_INST, 32'h0000_0000, instruction word presented when id_vld is 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  in_inst/in_pc carry a fetched instruction this cycle.
- in_inst  in  32  instruction word from SRAM.
- in_pc  in  32  PC of in_inst.
- flush  in  1  branch stomp; drop all not-yet-issued instructions.
- id_stall  in  1  decode cannot accept; hold ID outputs.
- fetch_hold  out  1  to fetch PC write enable; 1 = hold PC.
- id_vld  out  1  ID register holds a valid instruction.
- id_inst  out  32  instruction to decode.
- id_pc  out  32  PC of id_inst.
- occupancy  out  4  current queue entry count, 0..DEPTH.

Behaviour:
Reset and storage:
- Reset: id_vld=0, id_inst=NOP_INST, id_pc=0, count=0, rd/wr pointers=0, fetch_hold=0.
- Queue is a circular buffer: head pointer, tail pointer, count register.
- Pointers wrap explicitly from DEPTH-1 to 0; DEPTH need not be a power of 2.

fetch_hold:
- Combinational: fetch_hold = (count >= DEPTH-1).
- This leaves one free slot for the instruction already in flight from SRAM when hold first rises.

ID register update, priority order each cycle:
1. id_stall=1: id_vld, id_inst, id_pc hold their values regardless of flush.
2. flush=1: id_vld<=0, id_inst<=NOP_INST, id_pc unchanged.
3. count>0: pop head into the ID register, id_vld<=1.
4. count=0 and in_vld=1: bypass input straight into the ID register, id_vld<=1. Latency in_vld -> id_vld is 1 cycle.
5. Otherwise: id_vld<=0, id_inst<=NOP_INST.

Queue push:
- Push in_inst/in_pc at the tail when in_vld=1 and flush=0, unless the input was consumed by bypass (case 4).
- Simultaneous push and pop: count unchanged, both pointers advance.

flush:
- Sets count<=0 and rd=wr<=0; any in_vld in the same cycle is dropped.
- When flush and id_stall coincide, the ID register is not flushed. Its content is the branch delay slot and must survive.

Error condition:
- in_vld=1 while count=DEPTH and no pop this cycle is illegal.
- Simulation assertion; the data is dropped and count does not change.

occupancy:
- Equals count; registered, no combinational path from inputs.

Reset mid-operation:
- Reset overrides everything; the queue contents are discarded and outputs return to reset values on the next edge.

Optional Feature:
- Macro PPS_FETCH_QUEUE_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0], both saturating at 16'hFFFF and cleared by rst.
  - stall_cnt increments on each cycle where id_stall=1 and id_vld=1.
  - flush_cnt increments on each cycle where flush=1.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pps_pkg holds:
  - NOP_INST default 32'h0000_0000;
  - PC reset vector 32'hFFFF_FFFC;
  - a struct/typedef if_pkt_t {inst[31:0], pc[31:0]} used by both fetch and this block.
- One natural sub-module: pps_fifo_ram, a DEPTH x 64-bit register array with write port and asynchronous read at head.
- Control, bypass and ID register stay in the top module.

Test Plan:
- Reset then in_vld stream, pc 0x0,0x4,0x8, id_stall=0 -> id_pc 0x0,0x4,0x8 one cycle later each, occupancy stays 0, fetch_hold 0.
- id_stall=1 for 3 cycles while in_vld delivers 0x10,0x14 (DEPTH=2) -> occupancy 1 and fetch_hold 1, then occupancy 2. id_pc frozen; on release, issue order is 0x10 then 0x14 with no gap.
- Flush with occupancy 2, id_stall=0 -> next cycle id_vld=0, id_inst=NOP_INST, occupancy 0, fetch_hold 0. The in_vld present in the flush cycle (pc 0x20) is not issued.
- Flush with id_stall=1, ID holding pc 0x30 (delay slot) -> id_pc stays 0x30 with id_vld=1, queue empties.
- Assert rst while occupancy=2 -> next cycle id_vld=0, occupancy 0, id_pc 0. With STATS_EN, stall_cnt and flush_cnt also read 0.
- STATS_EN with 70000 stalled cycles -> stall_cnt saturates at 16'hFFFF and does not wrap.
